fetch_sequencer: RTL and testbench

Control block that sequences the program counter register and the instruction-memory fetch port. Each cycle it decides whether the PC holds or loads, and which value it loads: sequential PC+2, branch target or exception vector. It also issues the fetch request, tracks an outstanding multi-cycle memory access, and squashes fetches made stale by a redirect. It sits between the decode/branch logic, the PC register and instruction memory.

---
 rtl/fetch_sequencer.sv | 119 +++++++++++
 tb/tb_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC advance/hold control and single-outstanding instruction fetch sequencing
// with redirect squash, halt and fetch timeout.
module fetch_sequencer #(
    parameter logic [15:0] EXC_VECTOR = 16'h0002,
    parameter logic [3:0]  TIMEOUT    = 4'd15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc_cur,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    input  logic        exc,
    input  logic        halt,
    input  logic        mem_done,
    input  logic [15:0] mem_instr,
    output logic [15:0] pc_next,
    output logic        pc_hold,
    output logic        fetch_req,
    output logic [15:0] instr,
    output logic        instr_valid,
    output logic        halted,
    output logic        fetch_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;
    state_t      r_state, w_state_nx;
    logic        r_pend, r_pend_exc, r_squash, r_halt_lat, r_instr_valid;
    logic [15:0] r_pend_pc, r_instr;
    logic [3:0]  r_cnt;
    logic        w_deliver;
    logic [15:0] w_seq;
    assign w_seq       = pc_cur + 16'd2;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign halted      = r_state == HALT;
    always_comb begin
        w_state_nx = r_state;
        pc_hold    = 1'b1;
        pc_next    = 16'h0000;
        fetch_req  = 1'b0;
        fetch_err  = 1'b0;
        w_deliver  = 1'b0;
        case (r_state)
            IDLE: w_state_nx = REQ;
            REQ: begin
                if (halt) begin
                    w_state_nx = HALT;
                end else if (stall) begin
                    w_state_nx = REQ;
                end else if (exc || br_taken) begin
                    pc_hold = 1'b0;
                    pc_next = exc ? EXC_VECTOR : br_target;
                end else begin
                    fetch_req = 1'b1;
                    if (mem_done) begin
                        w_deliver = 1'b1;
                        pc_hold   = 1'b0;
                        pc_next   = w_seq;
                    end else begin
                        w_state_nx = WAIT;
                    end
                end
            end
            WAIT: begin
                // A redirect in the completion cycle squashes the returning instruction too.
                if (mem_done) begin
                    w_deliver  = !(r_squash || exc || br_taken);
                    pc_hold    = 1'b0;
                    pc_next    = exc ? EXC_VECTOR :
                                 (br_taken && !r_pend_exc) ? br_target :
                                 r_pend ? r_pend_pc : w_seq;
                    w_state_nx = (r_halt_lat || halt) ? HALT : REQ;
                end else if (r_cnt == TIMEOUT) begin
                    fetch_err  = 1'b1;
                    w_state_nx = HALT;
                end
            end
            HALT: w_state_nx = HALT;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pend        <= 1'b0;
            r_pend_exc    <= 1'b0;
            r_pend_pc     <= 16'h0000;
            r_squash      <= 1'b0;
            r_halt_lat    <= 1'b0;
            r_cnt         <= 4'd0;
            r_instr       <= 16'h0000;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_instr_valid <= w_deliver;
            if (w_deliver) r_instr <= mem_instr;
            if (r_state == WAIT && !mem_done) begin
                r_cnt <= r_cnt + 4'd1;
                if (halt) r_halt_lat <= 1'b1;
                // An exception target is never displaced by a later branch.
                if (exc) begin
                    r_pend     <= 1'b1;
                    r_pend_exc <= 1'b1;
                    r_pend_pc  <= EXC_VECTOR;
                    r_squash   <= 1'b1;
                end else if (br_taken) begin
                    r_pend   <= 1'b1;
                    r_squash <= 1'b1;
                    if (!r_pend_exc) r_pend_pc <= br_target;
                end
            end else begin
                r_cnt      <= 4'd0;
                r_pend     <= 1'b0;
                r_pend_exc <= 1'b0;
                r_squash   <= 1'b0;
                r_halt_lat <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed sequence with an instruction scoreboard for fetch_sequencer.
module tb_fetch_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] pc_cur = 16'h0000;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = 16'h0000;
    logic        exc = 1'b0;
    logic        halt = 1'b0;
    logic        mem_done = 1'b0;
    logic [15:0] mem_instr = 16'h0000;
    logic [15:0] pc_next, instr;
    logic        pc_hold, fetch_req, instr_valid, halted, fetch_err;
    int          tests = 0;
    int          fails = 0;
    logic [15:0] q[$];

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall), .br_taken(br_taken),
        .br_target(br_target), .exc(exc), .halt(halt), .mem_done(mem_done),
        .mem_instr(mem_instr), .pc_next(pc_next), .pc_hold(pc_hold), .fetch_req(fetch_req),
        .instr(instr), .instr_valid(instr_valid), .halted(halted), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then retire any delivered instruction against the scoreboard.
    task automatic tick();
        @(posedge clk);
        #1;
        if (instr_valid === 1'b1) begin
            if (q.size() == 0) chk("unexpected_valid", instr, 16'hxxxx);
            else chk("sb_instr", instr, q.pop_front());
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_hold"}, {15'd0, pc_hold}, 16'd1);
        chk({tag, "_pcn"}, pc_next, 16'h0000);
        chk({tag, "_req"}, {15'd0, fetch_req}, 16'd0);
        chk({tag, "_instr"}, instr, 16'h0000);
        chk({tag, "_ival"}, {15'd0, instr_valid}, 16'd0);
        chk({tag, "_halted"}, {15'd0, halted}, 16'd0);
        chk({tag, "_err"}, {15'd0, fetch_err}, 16'd0);
    endtask

    initial begin
        tick();
        tick();
        chk_reset("rst");
        // Zero-wait streaming from pc 0
        rst = 1'b1; mem_done = 1'b1; mem_instr = 16'hA000;
        settle();
        chk("idle_req", {15'd0, fetch_req}, 16'd0);
        tick();
        settle();
        chk("zw_req", {15'd0, fetch_req}, 16'd1);
        chk("zw_pcn", pc_next, 16'h0002);
        chk("zw_hold", {15'd0, pc_hold}, 16'd0);
        q.push_back(16'hA000);
        for (int i = 1; i < 4; i++) begin
            tick();
            mem_instr = 16'hA000 + 16'(i);
            settle();
            chk("zw_req_n", {15'd0, fetch_req}, 16'd1);
            chk("zw_pcn_n", pc_next, 16'h0002);
            chk("zw_hold_n", {15'd0, pc_hold}, 16'd0);
            q.push_back(mem_instr);
        end
        // Three-cycle memory latency at pc 0x0010
        tick();
        mem_done = 1'b0; pc_cur = 16'h0010;
        settle();
        chk("lat_req", {15'd0, fetch_req}, 16'd1);
        chk("lat_hold0", {15'd0, pc_hold}, 16'd1);
        for (int i = 0; i < 2; i++) begin
            tick();
            settle();
            chk("lat_hold", {15'd0, pc_hold}, 16'd1);
            chk("lat_noreq", {15'd0, fetch_req}, 16'd0);
        end
        tick();
        mem_done = 1'b1; mem_instr = 16'hB000;
        settle();
        chk("lat_adv", {15'd0, pc_hold}, 16'd0);
        chk("lat_pcn", pc_next, 16'h0012);
        q.push_back(16'hB000);
        // Branch during WAIT squashes the returning instruction
        tick();
        chk("lat_ival", {15'd0, instr_valid}, 16'd1);
        mem_done = 1'b0; pc_cur = 16'h0020;
        settle();
        chk("br_req", {15'd0, fetch_req}, 16'd1);
        tick();
        br_taken = 1'b1; br_target = 16'h0100;
        settle();
        chk("br_wait_hold", {15'd0, pc_hold}, 16'd1);
        tick();
        br_taken = 1'b0; br_target = 16'h0000; mem_done = 1'b1; mem_instr = 16'hC000;
        settle();
        chk("br_pcn", pc_next, 16'h0100);
        chk("br_hold", {15'd0, pc_hold}, 16'd0);
        tick();
        chk("br_squash", {15'd0, instr_valid}, 16'd0);
        pc_cur = 16'h0100; mem_instr = 16'hD000;
        settle();
        chk("br_next_req", {15'd0, fetch_req}, 16'd1);
        chk("br_next_pcn", pc_next, 16'h0102);
        q.push_back(16'hD000);
        // exc beats br_taken in REQ; no fetch that cycle
        tick();
        mem_done = 1'b0; exc = 1'b1; br_taken = 1'b1; br_target = 16'h0300;
        settle();
        chk("exc_pcn", pc_next, 16'h0002);
        chk("exc_hold", {15'd0, pc_hold}, 16'd0);
        chk("exc_noreq", {15'd0, fetch_req}, 16'd0);
        // Sequential wrap at 0xFFFE
        tick();
        exc = 1'b0; br_taken = 1'b0; pc_cur = 16'hFFFE; mem_done = 1'b1; mem_instr = 16'hE000;
        settle();
        chk("wrap_pcn", pc_next, 16'h0000);
        chk("wrap_hold", {15'd0, pc_hold}, 16'd0);
        chk("wrap_req", {15'd0, fetch_req}, 16'd1);
        q.push_back(16'hE000);
        // Stall held for four cycles
        for (int i = 0; i < 4; i++) begin
            tick();
            stall = 1'b1; mem_done = 1'b0;
            settle();
            chk("stall_req", {15'd0, fetch_req}, 16'd0);
            chk("stall_hold", {15'd0, pc_hold}, 16'd1);
        end
        // Timeout: fetch_err 15 cycles after WAIT entry
        tick();
        stall = 1'b0;
        settle();
        chk("to_req", {15'd0, fetch_req}, 16'd1);
        for (int k = 0; k < 15; k++) begin
            tick();
            settle();
            chk("to_noerr", {15'd0, fetch_err}, 16'd0);
            chk("to_nohalt", {15'd0, halted}, 16'd0);
        end
        tick();
        settle();
        chk("to_err", {15'd0, fetch_err}, 16'd1);
        tick();
        exc = 1'b1;
        settle();
        chk("halt_flag", {15'd0, halted}, 16'd1);
        chk("halt_errpulse", {15'd0, fetch_err}, 16'd0);
        chk("halt_hold", {15'd0, pc_hold}, 16'd1);
        chk("halt_noreq", {15'd0, fetch_req}, 16'd0);
        tick();
        settle();
        chk("halt_stay", {15'd0, halted}, 16'd1);
        chk("halt_instr_kept", instr, 16'hE000);
        // Restart, then async reset in the middle of WAIT
        exc = 1'b0; rst = 1'b0;
        settle();
        chk("rst2_halted", {15'd0, halted}, 16'd0);
        tick();
        rst = 1'b1; pc_cur = 16'h0040;
        tick();
        settle();
        chk("rs_req", {15'd0, fetch_req}, 16'd1);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_reset("mid_wait_rst");
        tick();
        rst = 1'b1;
        settle();
        chk("restart_idle", {15'd0, fetch_req}, 16'd0);
        tick();
        settle();
        chk("restart_req", {15'd0, fetch_req}, 16'd1);
        // halt latched in WAIT: access still completes, then HALT
        tick();
        halt = 1'b1;
        settle();
        chk("hw_nohalt", {15'd0, halted}, 16'd0);
        tick();
        halt = 1'b0; mem_done = 1'b1; mem_instr = 16'hF000;
        settle();
        chk("hw_pcn", pc_next, 16'h0042);
        q.push_back(16'hF000);
        tick();
        mem_done = 1'b0;
        settle();
        chk("hw_halted", {15'd0, halted}, 16'd1);
        chk("sb_drained", 16'(q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
